// File: rtl/led_uart_mmio.sv
// MMIO peripheral: LED and 7-seg registers, synchronized buttons/switches, 8N1 UART transmitter.
// Latency: zero wait states; read data is combinational, writes commit at the request edge.
// Backpressure: none; ready mirrors req, and a UART TX write while busy is dropped.
module led_uart_mmio #(
    parameter int                UART_DIV     = 868,
    parameter int                SEG_SCAN_DIV = 100000,
    parameter int                ADDR_W       = 32,
    parameter int                XLEN         = 32,
    parameter logic [ADDR_W-1:0] IO_BASE_ADDR = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmio_req,
    input  logic              mmio_we,
    input  logic [ADDR_W-1:0] mmio_addr,
    input  logic [XLEN-1:0]   mmio_wdata,
    output logic [XLEN-1:0]   mmio_rdata,
    output logic              mmio_ready,
    output logic [15:0]       led_out,
    output logic [7:0]        seg0,
    output logic [7:0]        seg1,
    output logic [7:0]        seg_an,
    input  logic [4:0]        btn_in,
    input  logic [7:0]        sw_in,
    output logic              uart_tx
);

    // Register map offsets from the block base; STAT busy flag sits in bit 0.
    localparam int IO_LED_OFFSET         = 'h00;
    localparam int IO_SEG_OFFSET         = 'h04;
    localparam int IO_BTN_OFFSET         = 'h08;
    localparam int IO_SW_OFFSET          = 'h0C;
    localparam int IO_UART_TX_OFFSET     = 'h10;
    localparam int IO_UART_STAT_OFFSET   = 'h14;
    localparam int IO_UART_STAT_BUSY_BIT = 0;

    localparam logic [ADDR_W-1:0] A_LED  = IO_BASE_ADDR + ADDR_W'(IO_LED_OFFSET);
    localparam logic [ADDR_W-1:0] A_SEG  = IO_BASE_ADDR + ADDR_W'(IO_SEG_OFFSET);
    localparam logic [ADDR_W-1:0] A_BTN  = IO_BASE_ADDR + ADDR_W'(IO_BTN_OFFSET);
    localparam logic [ADDR_W-1:0] A_SW   = IO_BASE_ADDR + ADDR_W'(IO_SW_OFFSET);
    localparam logic [ADDR_W-1:0] A_TX   = IO_BASE_ADDR + ADDR_W'(IO_UART_TX_OFFSET);
    localparam logic [ADDR_W-1:0] A_STAT = IO_BASE_ADDR + ADDR_W'(IO_UART_STAT_OFFSET);

    localparam int SCAN_W = $clog2(SEG_SCAN_DIV + 1);
    localparam int BAUD_W = $clog2(UART_DIV);

    typedef enum logic {S_IDLE, S_SEND} uart_state_t;

    // Standard hex glyphs, {dp,g,f,e,d,c,b,a}, dp never lit.
    function automatic logic [7:0] f_glyph(input logic [3:0] n);
        case (n)
            4'h0: f_glyph = 8'h3F;
            4'h1: f_glyph = 8'h06;
            4'h2: f_glyph = 8'h5B;
            4'h3: f_glyph = 8'h4F;
            4'h4: f_glyph = 8'h66;
            4'h5: f_glyph = 8'h6D;
            4'h6: f_glyph = 8'h7D;
            4'h7: f_glyph = 8'h07;
            4'h8: f_glyph = 8'h7F;
            4'h9: f_glyph = 8'h6F;
            4'hA: f_glyph = 8'h77;
            4'hB: f_glyph = 8'h7C;
            4'hC: f_glyph = 8'h39;
            4'hD: f_glyph = 8'h5E;
            4'hE: f_glyph = 8'h79;
            default: f_glyph = 8'h71;
        endcase
    endfunction

    logic [15:0]       r_led;
    logic [31:0]       r_seg;
    logic [4:0]        r_btn_s1, r_btn_s2;
    logic [7:0]        r_sw_s1, r_sw_s2;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_scan_idx;
    logic [7:0]        r_seg0, r_seg1, r_seg_an;

    uart_state_t       r_state, w_state_nxt;
    logic [BAUD_W-1:0] r_baud, w_baud_nxt;
    logic [3:0]        r_bit, w_bit_nxt;
    logic [8:0]        r_shift, w_shift_nxt;
    logic              r_tx, w_tx_nxt;

    logic [ADDR_W-1:0] w_addr_al;
    logic              w_wr;
    logic              w_busy;
    logic              w_tx_wr;
    logic [3:0]        w_nib_lo, w_nib_hi;
    logic [XLEN-1:0]   w_rdata;

    // Low two address bits are masked so any byte within a word hits that word.
    assign w_addr_al  = mmio_addr & ~ADDR_W'(3);
    assign w_wr       = mmio_req & mmio_we;
    assign w_tx_wr    = w_wr & (w_addr_al == A_TX);
    assign w_busy     = (r_state == S_SEND);
    assign mmio_ready = mmio_req;
    assign mmio_rdata = w_rdata;

    assign led_out = r_led;
    assign seg0    = r_seg0;
    assign seg1    = r_seg1;
    assign seg_an  = r_seg_an;
    assign uart_tx = r_tx;

    // Read mux: unmapped and write-only locations read as zero.
    always_comb begin
        w_rdata = '0;
        if (w_addr_al == A_LED)       w_rdata = XLEN'(r_led);
        else if (w_addr_al == A_SEG)  w_rdata = XLEN'(r_seg);
        else if (w_addr_al == A_BTN)  w_rdata = XLEN'(r_btn_s2);
        else if (w_addr_al == A_SW)   w_rdata = XLEN'(r_sw_s2);
        else if (w_addr_al == A_STAT) w_rdata[IO_UART_STAT_BUSY_BIT] = w_busy;
    end

    // Writable LED and seven-segment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
            r_seg <= '0;
        end else if (w_wr) begin
            if (w_addr_al == A_LED) r_led <= mmio_wdata[15:0];
            if (w_addr_al == A_SEG) r_seg <= mmio_wdata[31:0];
        end
    end

    // Two-flop synchronizers for the asynchronous buttons and switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_btn_s1 <= btn_in;
            r_btn_s2 <= r_btn_s1;
            r_sw_s1  <= sw_in;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_nib_lo = r_seg[{1'b0, r_scan_idx, 2'b00} +: 4];
    assign w_nib_hi = r_seg[{1'b1, r_scan_idx, 2'b00} +: 4];

    // Display scan: every SEG_SCAN_DIV cycles latch digit pair k / k+4, then advance k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg0     <= '0;
            r_seg1     <= '0;
            r_seg_an   <= '0;
        end else if (r_scan_cnt == SCAN_W'(SEG_SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
            r_seg0     <= f_glyph(w_nib_lo);
            r_seg1     <= f_glyph(w_nib_hi);
            r_seg_an   <= 8'h11 << r_scan_idx;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // UART state register; tx idles high so a reset mid-frame leaves the line quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // UART next state: start bit on accept, then shift {stop, data} out LSB first.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        case (r_state)
            S_IDLE: begin
                if (w_tx_wr) begin
                    w_state_nxt = S_SEND;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = {1'b1, mmio_wdata[7:0]};
                    w_tx_nxt    = 1'b0;
                end
            end
            default: begin
                if (r_baud == BAUD_W'(UART_DIV - 1)) begin
                    w_baud_nxt = '0;
                    if (r_bit == 4'd9) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b1, r_shift[8:1]};
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_led_uart_mmio.sv
// Bench for led_uart_mmio: directed MMIO traffic with a queue-based scoreboard.
// Stimulus pushes expected read data / output observations; a negedge monitor pops and compares.
// Runs with UART_DIV=8 and SEG_SCAN_DIV=4 to keep frames and scan periods short.
module tb_led_uart_mmio;

    localparam int          UART_DIV = 8;
    localparam int          SCAN_DIV = 4;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam logic [31:0] A_LED    = BASE + 32'h00;
    localparam logic [31:0] A_SEG    = BASE + 32'h04;
    localparam logic [31:0] A_BTN    = BASE + 32'h08;
    localparam logic [31:0] A_SW     = BASE + 32'h0C;
    localparam logic [31:0] A_TX     = BASE + 32'h10;
    localparam logic [31:0] A_STAT   = BASE + 32'h14;
    localparam logic [31:0] A_NONE   = BASE + 32'h40;

    localparam int SEL_LED = 0, SEL_TX = 1, SEL_AN = 2, SEL_SEG0 = 3, SEL_SEG1 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmio_req = 1'b0;
    logic        mmio_we = 1'b0;
    logic [31:0] mmio_addr = '0;
    logic [31:0] mmio_wdata = '0;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;
    logic [15:0] led_out;
    logic [7:0]  seg0, seg1, seg_an;
    logic [4:0]  btn_in = '0;
    logic [7:0]  sw_in = '0;
    logic        uart_tx;

    led_uart_mmio #(
        .UART_DIV     (UART_DIV),
        .SEG_SCAN_DIV (SCAN_DIV),
        .ADDR_W       (32),
        .XLEN         (32),
        .IO_BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_req   (mmio_req),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready),
        .led_out    (led_out),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg_an     (seg_an),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] exp; } rd_t;
    typedef struct { string name; int sel; logic [31:0] exp; } obs_t;

    rd_t  rd_q[$];
    obs_t obs_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Hex glyph table, {dp,g,f,e,d,c,b,a}.
    logic [7:0] GLY [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [31:0] obs_val(int sel);
        case (sel)
            SEL_LED:  return {16'h0, led_out};
            SEL_TX:   return {31'h0, uart_tx};
            SEL_AN:   return {24'h0, seg_an};
            SEL_SEG0: return {24'h0, seg0};
            default:  return {24'h0, seg1};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: ready must track req, reads pop the read queue, observations drain the obs queue.
    always @(negedge clk) begin
        rd_t  e;
        obs_t o;
        check("ready", {31'h0, mmio_ready}, {31'h0, mmio_req});
        if (mmio_req && !mmio_we) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read: addr 0x%08h data 0x%08h, expected no read", mmio_addr, mmio_rdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, mmio_rdata, e.exp);
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check(o.name, obs_val(o.sel), o.exp);
        end
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        mmio_req = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
        @(posedge clk);
        #1;
        mmio_req = 1'b0; mmio_we = 1'b0;
    endtask

    task automatic rd(logic [31:0] a, logic [31:0] exp, string name);
        rd_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = a;
        @(posedge clk);
        #1;
        mmio_req = 1'b0;
    endtask

    task automatic observe(int sel, logic [31:0] exp, string name);
        obs_t o;
        o.name = name;
        o.sel  = sel;
        o.exp  = exp;
        obs_q.push_back(o);
    endtask

    // Frame issued at edge c=0; line sampled mid-bit at c = 4 + 8*i.
    task automatic uart_frame(logic [7:0] b, bit extra, logic [7:0] xb);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        wr(A_TX, {24'h0, b});
        if (extra) wr(A_TX, {24'h0, xb});
        else       tick(1);
        rd(A_STAT, 32'h1, "busy_after_tx");
        tick(2);
        for (int i = 0; i < 10; i++) begin
            observe(SEL_TX, {31'h0, fr[i]}, "uart_bit");
            if (i < 9) tick(UART_DIV);
        end
        tick(3);
        rd(A_STAT, 32'h1, "busy_last_cycle");
        rd(A_STAT, 32'h0, "busy_cleared");
        tick(3);
        observe(SEL_TX, 32'h1, "uart_idle");
        rd(A_STAT, 32'h0, "busy_idle");
        if (extra) begin
            for (int i = 0; i < 3; i++) begin
                tick(UART_DIV);
                observe(SEL_TX, 32'h1, "no_second_frame");
            end
            rd(A_STAT, 32'h0, "busy_after_drop");
        end
    endtask

    task automatic wait_an(logic [7:0] v, bit eq);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if ((seg_an == v) == eq) ok = 1'b1;
            else tick(1);
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL seg_wait: seg_an 0x%02h, expected to reach 0x%02h (eq=%0d) within 64 cycles", seg_an, v, eq);
        end
    endtask

    task automatic seg_check(logic [31:0] val);
        logic [7:0] an;
        wr(A_SEG, val);
        rd(A_SEG, val, "seg_readback");
        wait_an(8'h11, 1'b0);
        wait_an(8'h11, 1'b1);
        for (int k = 0; k < 4; k++) begin
            an = 8'h11 << k;
            observe(SEL_AN, {24'h0, an}, "seg_an");
            observe(SEL_SEG0, {24'h0, GLY[val[4*k +: 4]]}, "seg0");
            observe(SEL_SEG1, {24'h0, GLY[val[4*k+16 +: 4]]}, "seg1");
            if (k == 0) begin
                tick(SCAN_DIV - 1);
                observe(SEL_AN, 32'h11, "seg_an_hold");
                tick(1);
            end else begin
                tick(SCAN_DIV);
            end
        end
        observe(SEL_AN, 32'h11, "seg_an_wrap");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [15:0] last_led;

        tick(2);
        observe(SEL_LED,  32'h0, "rst_led");
        observe(SEL_TX,   32'h1, "rst_uart_tx");
        observe(SEL_AN,   32'h0, "rst_seg_an");
        observe(SEL_SEG0, 32'h0, "rst_seg0");
        observe(SEL_SEG1, 32'h0, "rst_seg1");
        tick(1);
        rst_n = 1'b1;
        rd(A_LED,  32'h0, "rst_led_reg");
        rd(A_SEG,  32'h0, "rst_seg_reg");
        rd(A_STAT, 32'h0, "rst_busy");
        rd(A_SW,   32'h0, "rst_sw");

        wr(A_LED, 32'h0000A5A5);
        rd(A_LED, 32'h0000A5A5, "led_a5a5");
        observe(SEL_LED, 32'h0000A5A5, "led_out_a5a5");

        for (int i = 0; i < 20; i++) begin
            v = $urandom;
            wr(A_LED, v);
            rd(A_LED, {16'h0, v[15:0]}, "led_rand");
            observe(SEL_LED, {16'h0, v[15:0]}, "led_out_rand");
            last_led = v[15:0];
        end

        rd(A_LED + 32'd3, {16'h0, last_led}, "led_byte_alias");
        wr(A_NONE, 32'hDEAD_BEEF);
        rd(A_LED, {16'h0, last_led}, "unmapped_write_ignored");
        rd(A_NONE, 32'h0, "unmapped_read");
        rd(A_TX, 32'h0, "tx_read_zero");
        rd(A_LED ^ 32'h1000_0000, 32'h0, "high_addr_bits");

        sw_in  = 8'hA5;
        btn_in = 5'b10011;
        tick(3);
        rd(A_SW,  32'h000000A5, "sw_a5");
        rd(A_BTN, 32'h00000013, "btn_13");
        sw_in  = 8'h3C;
        btn_in = 5'b01100;
        tick(1);
        rd(A_SW,  32'h000000A5, "sw_latency_old");
        rd(A_SW,  32'h0000003C, "sw_3c");
        rd(A_BTN, 32'h0000000C, "btn_0c");

        uart_frame(8'h55, 1'b0, 8'h00);
        uart_frame(8'h55, 1'b1, 8'hFF);
        uart_frame(8'hA3, 1'b0, 8'h00);

        seg_check(32'h7654_3210);
        seg_check(32'hFEDC_BA98);

        tick(2);
        check("rd_queue_drained", rd_q.size(), 32'h0);
        check("obs_queue_drained", obs_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
